mult_secuencial_qfmt: RTL and testbench

//   Sequential signed fixed-point multiplier (radix-2 Booth, one step per clock).

---
 rtl/mult_secuencial_qfmt.sv | 76 +++++++
 tb/tb_mult_secuencial_qfmt.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mult_secuencial_qfmt.sv
// mult_secuencial_qfmt: radix-2 Booth sequential signed Q-format multiplier, one step per clock
module mult_secuencial_qfmt #(
   parameter int N  = 25,
   parameter int MA = 4,
   parameter int MB = 4,
   parameter int FA = 20,
   parameter int FB = 20
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   Dato_A,
   input  logic [N-1:0]   Dato_B,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] Datos_Sum
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (N != 1 + MA + FA || N != 1 + MB + FB) begin : g_qfmt_check
      $error("operand width does not match the Q format");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [N-1:0]  a, q, q_sh;
   logic [N:0]    acc, sum, acc_sh;
   logic          q_1, last;
   logic [CW-1:0] cnt;

   // acc carries one guard bit so negating the most negative A cannot overflow
   always_comb begin
      sum    = {q[0], q_1} == 2'b01 ? acc + {a[N-1], a} :
               {q[0], q_1} == 2'b10 ? acc - {a[N-1], a} : acc;
      acc_sh = {sum[N], sum[N:1]};
      q_sh   = {sum[0], q[N-1:1]};
      last   = cnt == LAST;
   end

   always_comb begin
      state_nxt = state == IDLE ? (start ? CALC : IDLE) :
                  state == CALC ? (last ? DONE : CALC) : IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a         <= '0;
         q         <= '0;
         acc       <= '0;
         q_1       <= 1'b0;
         cnt       <= '0;
         Datos_Sum <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            a   <= Dato_A;
            q   <= Dato_B;
            acc <= '0;
            q_1 <= 1'b0;
            cnt <= '0;
         end else if (state == CALC) begin
            acc <= acc_sh;
            q   <= q_sh;
            q_1 <= q[0];
            cnt <= cnt + 1'b1;
            if (last) Datos_Sum <= {acc_sh[N-1:0], q_sh};
         end
      end
   end

   assign busy = state != IDLE;
   assign done = state == DONE;
endmodule

// File: tb/tb_mult_secuencial_qfmt.sv
// tb_mult_secuencial_qfmt: vector table, handshake corner cases and random products vs plain signed multiply
module tb_mult_secuencial_qfmt;
   localparam int N = 25;
   localparam int W = 2 * N;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] Dato_A = '0;
   logic [N-1:0] Dato_B = '0;
   logic         busy, done;
   logic [W-1:0] Datos_Sum;

   int errors = 0;
   int checks = 0;

   mult_secuencial_qfmt #(.N(N), .MA(4), .MB(4), .FA(20), .FB(20)) dut (
      .clk(clk), .reset(reset), .start(start), .Dato_A(Dato_A), .Dato_B(Dato_B),
      .busy(busy), .done(done), .Datos_Sum(Datos_Sum)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [W-1:0] p;
   } vec_t;

   function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
      logic signed [W-1:0] sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [W-1:0] res, output int lat);
      @(negedge clk);
      Dato_A = a;
      Dato_B = b;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      Dato_A = N'($urandom);
      Dato_B = N'($urandom);
      lat    = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 64'(lat), 64'(N + 1));
      res = Datos_Sum;
   endtask

   vec_t         tbl[6];
   logic [N-1:0] corner[4];
   logic [N-1:0] ea[3], eb[3];
   logic [W-1:0] res, prev;
   int           lat, cyc, last_done, k;
   logic         stable;

   initial begin
      tbl[0] = '{25'h0180000, 25'h0200000, 50'h0_0300_0000_0000};
      tbl[1] = '{25'h1F00000, 25'h0100000, 50'h3_FF00_0000_0000};
      tbl[2] = '{25'h1F00000, 25'h1F00000, 50'h0_0100_0000_0000};
      tbl[3] = '{25'h1000000, 25'h1000000, 50'h1_0000_0000_0000};
      tbl[4] = '{25'h0000000, 25'h1234567, 50'h0_0000_0000_0000};
      tbl[5] = '{25'h1FFFFFF, 25'h0FFFFFF, 50'h3_FFFF_FF00_0001};
      corner = '{25'h1000000, 25'h0FFFFFF, 25'h1FFFFFF, 25'h0000001};

      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_sum", 64'(Datos_Sum), 64'd0);
      reset = 1'b0;

      // directed vectors: value, latency, single-cycle done
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].a, tbl[i].b, res, lat);
         chk($sformatf("vec%0d_sum", i), 64'(res), 64'(tbl[i].p));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(N + 1));
         chk($sformatf("vec%0d_busy_in_done", i), 64'(busy), 64'd1);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
         chk($sformatf("vec%0d_sum_hold", i), 64'(Datos_Sum), 64'(tbl[i].p));
      end

      // start held high: back-to-back ops every N+2 cycles, Datos_Sum stable between pulses
      ea = '{25'h0180000, 25'h1000000, 25'h0ABCDEF};
      eb = '{25'h0200000, 25'h0FFFFFF, 25'h1234567};
      @(negedge clk);
      Dato_A = ea[0];
      Dato_B = eb[0];
      start  = 1'b1;
      prev = Datos_Sum;
      last_done = 0;
      k = 0;
      stable = 1'b1;
      for (cyc = 1; cyc <= 3 * (N + 2) + 4 && k < 3; cyc++) begin
         @(negedge clk);
         if (done) begin
            chk($sformatf("b2b%0d_sum", k), 64'(Datos_Sum), 64'(model(ea[k], eb[k])));
            chk($sformatf("b2b%0d_spacing", k), 64'(cyc - last_done), 64'(k == 0 ? N + 1 : N + 2));
            chk($sformatf("b2b%0d_stable", k), 64'(stable), 64'd1);
            last_done = cyc;
            prev = Datos_Sum;
            stable = 1'b1;
            k++;
            if (k < 3) begin
               Dato_A = ea[k];
               Dato_B = eb[k];
            end else start = 1'b0;
         end else if (Datos_Sum !== prev) stable = 1'b0;
      end
      chk("b2b_count", 64'(k), 64'd3);
      start = 1'b0;
      repeat (N + 4) @(negedge clk);

      // reset in the middle of CALC discards the operation
      @(negedge clk);
      Dato_A = 25'h0180000;
      Dato_B = 25'h0200000;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("midcalc_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midcalc_busy", 64'(busy), 64'd0);
      chk("midcalc_done", 64'(done), 64'd0);
      chk("midcalc_sum", 64'(Datos_Sum), 64'd0);
      reset = 1'b0;
      run_op(25'h1F00000, 25'h0100000, res, lat);
      chk("after_reset_sum", 64'(res), 64'h3_FF00_0000_0000);
      chk("after_reset_latency", 64'(lat), 64'(N + 1));

      // random products, biased towards extreme operands
      for (int i = 0; i < 1000; i++) begin
         logic [N-1:0] ra, rb;
         ra = $urandom_range(0, 7) == 0 ? corner[$urandom_range(0, 3)] : N'($urandom);
         rb = $urandom_range(0, 7) == 0 ? corner[$urandom_range(0, 3)] : N'($urandom);
         run_op(ra, rb, res, lat);
         chk($sformatf("rand%0d_sum a=%h b=%h", i, ra, rb), 64'(res), 64'(model(ra, rb)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
